sipo_frame_ctrl: RTL and testbench

//  Frame controller that sequences a serial-in/parallel-out capture path.
//  - Detects a start bit, shifts exactly WIDTH data bits into an internal SIPO register,

---
 rtl/sipo_frame_ctrl.sv | 137 +++++++++++++
 tb/tb_sipo_frame_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/sipo_frame_ctrl.sv
// sipo_frame_ctrl: start-bit framed serial-in/parallel-out capture with a
// valid/ready word output and sticky back-pressure overrun flag.
// Optional even-parity trailer bit enabled by defining SIPO_PARITY_EN.
module sipo_frame_ctrl #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sin,
  input  logic             sin_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun,
  output logic             parity_err
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

`ifdef SIPO_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2, HOLD = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, HOLD = 2'd3} state_t;
`endif

  state_t           r_state, w_state;
  logic [CW-1:0]    r_cnt, w_cnt;
  logic [WIDTH-1:0] r_sh, w_sh;
  logic [WIDTH-1:0] r_data, w_data;
  logic             r_valid, w_valid;
  logic             r_ovr, w_ovr;
  logic             r_perr, w_perr;
  logic [WIDTH-1:0] w_sh_shift;
  logic             w_start;

  // Shift register contents after accepting the current serial bit
  assign w_sh_shift = MSB_FIRST ? {r_sh[WIDTH-2:0], sin} : {sin, r_sh[WIDTH-1:1]};
  assign w_start    = sin_valid & sin & en;

  // State and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sh    <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
      r_perr  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_sh    <= w_sh;
      r_data  <= w_data;
      r_valid <= w_valid;
      r_ovr   <= w_ovr;
      r_perr  <= w_perr;
    end
  end

  // Next-state and next-datapath logic
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_sh    = r_sh;
    w_data  = r_data;
    w_valid = r_valid;
    w_ovr   = r_ovr;
    w_perr  = r_perr;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_state = SHIFT;
          w_cnt   = '0;
        end
      end
      SHIFT: begin
        if (!en) begin
          w_state = IDLE;
          w_cnt   = '0;
        end else if (sin_valid) begin
          w_sh = w_sh_shift;
          if (r_cnt == LAST_IDX) begin
            w_cnt = '0;
`ifdef SIPO_PARITY_EN
            w_state = PARITY;
`else
            w_data  = w_sh_shift;
            w_valid = 1'b1;
            w_state = HOLD;
`endif
          end else begin
            w_cnt = r_cnt + CW'(1);
          end
        end
      end
`ifdef SIPO_PARITY_EN
      PARITY: begin
        if (!en) begin
          w_state = IDLE;
          w_cnt   = '0;
        end else if (sin_valid) begin
          w_data  = r_sh;
          w_valid = 1'b1;
          w_perr  = (^r_sh) ^ sin;
          w_state = HOLD;
        end
      end
`endif
      HOLD: begin
        if (r_valid && out_ready) begin
          w_valid = 1'b0;
          w_perr  = 1'b0;
          w_cnt   = '0;
          // A start bit on the handshake edge begins the next frame immediately
          w_state = w_start ? SHIFT : IDLE;
        end else if (sin_valid) begin
          w_ovr = 1'b1;
        end
      end
      default: begin
        w_state = IDLE;
      end
    endcase
  end

  assign out_data   = r_data;
  assign out_valid  = r_valid;
  assign overrun    = r_ovr;
  assign parity_err = r_perr;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Bench for sipo_frame_ctrl: two instances (MSB-first and LSB-first) share
// stimulus; a queue-based frame model is compared every cycle, plus literal
// checks of the expected words. Honours SIPO_PARITY_EN when defined.
module tb_sipo_frame_ctrl;
  localparam int unsigned W = 4;
`ifdef SIPO_PARITY_EN
  localparam int unsigned P = 1;
`else
  localparam int unsigned P = 0;
`endif

  logic clk, rst, en, sin, sin_valid, out_ready;
  logic [W-1:0] d_m, d_l;
  logic v_m, v_l, b_m, b_l, o_m, o_l, p_m, p_l;

  int total = 0;
  int bad   = 0;
  bit chk_on = 0;

  sipo_frame_ctrl #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .en(en), .sin(sin), .sin_valid(sin_valid),
    .out_data(d_m), .out_valid(v_m), .out_ready(out_ready),
    .busy(b_m), .overrun(o_m), .parity_err(p_m));

  sipo_frame_ctrl #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .en(en), .sin(sin), .sin_valid(sin_valid),
    .out_data(d_l), .out_valid(v_l), .out_ready(out_ready),
    .busy(b_l), .overrun(o_l), .parity_err(p_l));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Frame model: 0 = waiting for start, 1 = collecting bits, 2 = word held
  int           m_phase = 0;
  logic         m_bits[$];
  logic [W-1:0] m_word_m, m_word_l;
  logic         m_valid, m_ovr, m_perr, m_dk;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_bits.delete();
      m_word_m = '0; m_word_l = '0;
      m_valid = 0; m_ovr = 0; m_perr = 0; m_dk = 1;
      chk_on = 1;
    end else begin
      case (m_phase)
        0: if (sin_valid && sin && en) begin m_phase = 1; m_bits.delete(); end
        1: if (!en) begin
             m_phase = 0; m_bits.delete();
           end else if (sin_valid) begin
             m_bits.push_back(sin);
             if (m_bits.size() == W + P) begin
               m_perr = 0;
               for (int i = 0; i < W; i++) begin
                 m_word_m[W-1-i] = m_bits[i];
                 m_word_l[i]     = m_bits[i];
               end
               if (P == 1) for (int i = 0; i < W + 1; i++) m_perr = m_perr ^ m_bits[i];
               m_valid = 1; m_dk = 1; m_phase = 2;
             end
           end
        default: if (out_ready) begin
             m_valid = 0; m_perr = 0; m_dk = 0;
             m_phase = (sin_valid && sin && en) ? 1 : 0;
             m_bits.delete();
           end else if (sin_valid) begin
             m_ovr = 1;
           end
      endcase
    end
  end

  // Compare both instances against the model on every falling edge
  always @(negedge clk) begin
    if (chk_on) begin
      chk("busy_m", 32'(b_m), 32'(m_phase != 0));
      chk("busy_l", 32'(b_l), 32'(m_phase != 0));
      chk("valid_m", 32'(v_m), 32'(m_valid));
      chk("valid_l", 32'(v_l), 32'(m_valid));
      chk("ovr_m", 32'(o_m), 32'(m_ovr));
      chk("ovr_l", 32'(o_l), 32'(m_ovr));
      chk("perr_m", 32'(p_m), 32'(m_perr));
      chk("perr_l", 32'(p_l), 32'(m_perr));
      if (m_dk) begin
        chk("data_m", 32'(d_m), 32'(m_word_m));
        chk("data_l", 32'(d_l), 32'(m_word_l));
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic sbit(input logic s);
    sin_valid = 1'b1; sin = s; step();
  endtask

  task automatic idle(input int n);
    sin_valid = 1'b0; sin = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  // Data bits d[3] first, then the parity bit when that build is selected
  task automatic data_bits(input logic [3:0] d, input logic p);
    logic [3:0] dd;
    dd = d;
    for (int i = 3; i >= 0; i--) sbit(dd[i]);
    if (P == 1) sbit(p);
    sin_valid = 1'b0;
  endtask

  task automatic frame(input logic [3:0] d);
    sbit(1'b1);
    data_bits(d, ^d);
  endtask

  task automatic deliver();
    out_ready = 1'b1; idle(1); out_ready = 1'b0;
    chk("hs_valid", 32'(v_m), 32'd0);
    chk("hs_busy", 32'(b_m), 32'd0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; sin = 1'b0; sin_valid = 1'b0; out_ready = 1'b0;
    idle(2);
    rst = 1'b0;
    chk("rst_data", 32'(d_m), 32'd0);
    chk("rst_valid", 32'(v_m), 32'd0);
    chk("rst_busy", 32'(b_m), 32'd0);

    // Basic capture, both bit orders
    frame(4'b1011);
    chk("t2_valid", 32'(v_m), 32'd1);
    chk("t2_msb", 32'(d_m), 32'h0B);
    chk("t2_lsb", 32'(d_l), 32'h0D);
    deliver();

    // Back-pressure: word held, stray strobe sets sticky overrun
    frame(4'b1011);
    idle(2); sbit(1'b0); idle(2);
    chk("t3_ovr", 32'(o_m), 32'd1);
    chk("t3_hold", 32'(d_m), 32'h0B);
    chk("t3_valid", 32'(v_m), 32'd1);
    deliver();
    chk("t3_ovr_sticky", 32'(o_m), 32'd1);

    // Reset mid-frame clears everything including overrun
    sbit(1'b1); sbit(1'b1); sbit(1'b0);
    sin_valid = 1'b0; rst = 1'b1; idle(2); rst = 1'b0;
    chk("t1_busy", 32'(b_m), 32'd0);
    chk("t1_ovr", 32'(o_m), 32'd0);
    chk("t1_data", 32'(d_m), 32'd0);
    frame(4'b0110);
    chk("t1_word", 32'(d_m), 32'h06);
    chk("t1_word_l", 32'(d_l), 32'h06);
    deliver();

    // Abort by en=0 after two data bits
    sbit(1'b1); sbit(1'b1); sbit(1'b0);
    sin_valid = 1'b0; en = 1'b0; idle(1);
    chk("t4_busy", 32'(b_m), 32'd0);
    chk("t4_valid", 32'(v_m), 32'd0);
    en = 1'b1;
    frame(4'b0110);
    chk("t4_word", 32'(d_m), 32'h06);
    chk("t4_ovr", 32'(o_m), 32'd0);
    deliver();

    // Handshake edge coincides with next start bit
    frame(4'b1011);
    out_ready = 1'b1; sbit(1'b1); out_ready = 1'b0;
    chk("t5_valid0", 32'(v_m), 32'd0);
    chk("t5_busy", 32'(b_m), 32'd1);
    data_bits(4'b1100, 1'b0);
    chk("t5_valid", 32'(v_m), 32'd1);
    chk("t5_msb", 32'(d_m), 32'h0C);
    chk("t5_lsb", 32'(d_l), 32'h03);
    deliver();

`ifdef SIPO_PARITY_EN
    sbit(1'b1); data_bits(4'b1011, 1'b1);
    chk("t6_valid_a", 32'(v_m), 32'd1);
    chk("t6_perr_a", 32'(p_m), 32'd0);
    deliver();
    sbit(1'b1); data_bits(4'b1011, 1'b0);
    chk("t6_valid_b", 32'(v_m), 32'd1);
    chk("t6_perr_b", 32'(p_m), 32'd1);
    deliver();
    chk("t6_perr_clr", 32'(p_m), 32'd0);
`endif

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
